jfifo_buffer: RTL and testbench

JFIFO_BUFFER -- requirements
Module: jfifo_buffer

---
 rtl/jbuf_pkg.sv | 13 +
 rtl/jfifo_mem.sv | 34 +++
 rtl/jfifo_buffer.sv | 81 ++++++++
 tb/tb_jfifo_buffer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/jbuf_pkg.sv
// Shared constants for the jfifo buffer.
// Default geometry and pointer-width derivation.
package jbuf_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Pointer width needed to index DEPTH entries.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/jfifo_mem.sv
// Storage array for the jfifo buffer.
// One write port, one asynchronous read port, cleared on reset.
module jfifo_mem
    import jbuf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry; reset clears every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jfifo_buffer.sv
// Synchronous FIFO with valid/ready ports.
// Pointers, occupancy and a sticky overflow flag live here.
module jfifo_buffer
    import jbuf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [ptr_w(DEPTH):0]       count,
    output logic                        overflow
);

    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    jfifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    // Pointers advance on their own event; power-of-two depth wraps them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy tracks push/pop; simultaneous events cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag: any word offered while full is dropped and recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jfifo_buffer.sv
// Directed self-checking bench for jfifo_buffer.
// Vectors with hand-computed expectations.
module tb_jfifo_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [3:0] count;
    logic       overflow;

    int n_chk  = 0;
    int n_pass = 0;

    jfifo_buffer #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state without any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_out_data", 32'(out_data), 0);
        step();
        rst = 1'b0;

        // first push, one-cycle latency
        push_one(8'h00);
        chk("p0_out_valid", 32'(out_valid), 1);
        chk("p0_out_data", 32'(out_data), 8'h00);
        chk("p0_count", 32'(count), 1);

        // fill, overflow, drain in order
        do_reset();
        for (int i = 1; i <= 8; i++) push_one(8'(i));
        chk("full_count", 32'(count), 8);
        chk("full_in_ready", 32'(in_ready), 0);
        push_one(8'h09);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(out_data), 32'(i));
            step();
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // empty with out_ready held high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_count", 32'(count), 0);
            chk("empty_out_valid", 32'(out_valid), 0);
        end
        out_ready = 1'b0;

        // streaming at count=3, pointers wrap several times
        do_reset();
        for (int i = 0; i < 3; i++) push_one(8'(8'h10 + i));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 8'(8'h13 + k);
            chk("stream_data", 32'(out_data), 32'(8'h10 + k));
            step();
            chk("stream_count", 32'(count), 3);
        end
        in_valid = 1'b0;
        for (int k = 20; k < 23; k++) begin
            chk("stream_tail", 32'(out_data), 32'(8'h10 + k));
            step();
        end
        chk("stream_empty", 32'(count), 0);
        out_ready = 1'b0;

        // full with offer and pop on the same edge
        do_reset();
        for (int i = 0; i < 8; i++) push_one(8'(8'h20 + i));
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fullpop_count", 32'(count), 7);
        chk("fullpop_ovf", 32'(overflow), 1);
        for (int i = 1; i < 8; i++) begin
            chk("fullpop_data", 32'(out_data), 32'(8'h20 + i));
            step();
        end
        chk("fullpop_empty", 32'(count), 0);
        out_ready = 1'b0;

        // asynchronous reset between edges with count=5, overflow set
        do_reset();
        for (int i = 0; i < 8; i++) push_one(8'(8'h30 + i));
        push_one(8'hEE);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        chk("pre_rst_count", 32'(count), 5);
        chk("pre_rst_ovf", 32'(overflow), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_overflow", 32'(overflow), 0);
        chk("arst_out_data", 32'(out_data), 0);
        step();
        rst = 1'b0;

        // first edge after release accepts a push
        push_one(8'h55);
        chk("post_rst_count", 32'(count), 1);
        chk("post_rst_data", 32'(out_data), 8'h55);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
